// File: rtl/axi_hp_slave_mem_if.sv
// AXI4 bus bundle between the axi_hp burst master and its memory responder.
// No IDs: one transaction in flight at a time.
interface axi_hp_slave_mem_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR;
    logic [7:0]                      AWLEN;
    logic                            AWVALID;
    logic                            AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB;
    logic                            WLAST;
    logic                            WVALID;
    logic                            WREADY;
    logic [1:0]                      BRESP;
    logic                            BVALID;
    logic                            BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR;
    logic [7:0]                      ARLEN;
    logic                            ARVALID;
    logic                            ARREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA;
    logic [1:0]                      RRESP;
    logic                            RLAST;
    logic                            RVALID;
    logic                            RREADY;

    modport master (
        output AWADDR, AWLEN, AWVALID, WDATA, WSTRB, WLAST, WVALID,
        output BREADY, ARADDR, ARLEN, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID,
        input  ARREADY, RDATA, RRESP, RLAST, RVALID
    );

    modport slave (
        input  AWADDR, AWLEN, AWVALID, WDATA, WSTRB, WLAST, WVALID,
        input  BREADY, ARADDR, ARLEN, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID,
        output ARREADY, RDATA, RRESP, RLAST, RVALID
    );
endinterface

// File: rtl/axi_hp_slave_mem.sv
// AXI4 INCR-burst memory responder for the axi_hp M00_AXI master.
// Serves one burst at a time from an internal word array.
module axi_hp_slave_mem #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_MEM_AW           = 10
) (
    input  logic               ACLK,
    input  logic               ARESET,
    axi_hp_slave_mem_if.slave  s_axi
);
    localparam int DEPTH = 1 << C_MEM_AW;
    localparam int NB    = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_LIM =
        C_S_AXI_ADDR_WIDTH'(4 * DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WDATA,
        S_WRESP,
        S_RDATA
    } state_t;

    state_t state, state_n;

    logic [C_S_AXI_DATA_WIDTH-1:0] mem [DEPTH];

    logic                          rdy_q;
    logic                          wr_pri;
    logic                          err;
    logic                          wl_err;
    logic [C_MEM_AW-1:0]           idx;
    logic [7:0]                    cnt;
    logic [7:0]                    len;
    logic                          bvalid_q;
    logic [1:0]                    bresp_q;
    logic                          rvalid_q;
    logic [1:0]                    rresp_q;
    logic                          rlast_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;

    logic                both, aw_hs, ar_hs, w_hs, b_hs, r_hs;
    logic                w_last, wl_bad, aw_err, ar_err;
    logic [C_MEM_AW-1:0] aw_idx, ar_idx;

    // Ready is registered; on a collision only the current winner sees it.
    assign both          = s_axi.AWVALID && s_axi.ARVALID;
    assign s_axi.AWREADY = rdy_q && !(both && !wr_pri);
    assign s_axi.ARREADY = rdy_q && !(both && wr_pri);
    assign s_axi.WREADY  = (state == S_WDATA);
    assign s_axi.BVALID  = bvalid_q;
    assign s_axi.BRESP   = bresp_q;
    assign s_axi.RVALID  = rvalid_q;
    assign s_axi.RRESP   = rresp_q;
    assign s_axi.RLAST   = rlast_q;
    assign s_axi.RDATA   = rdata_q;

    assign aw_hs  = s_axi.AWVALID && s_axi.AWREADY;
    assign ar_hs  = s_axi.ARVALID && s_axi.ARREADY;
    assign w_hs   = s_axi.WVALID && s_axi.WREADY;
    assign b_hs   = bvalid_q && s_axi.BREADY;
    assign r_hs   = rvalid_q && s_axi.RREADY;
    assign w_last = (cnt == len);
    assign wl_bad = (s_axi.WLAST != w_last);
    assign aw_err = (s_axi.AWADDR >= ADDR_LIM);
    assign ar_err = (s_axi.ARADDR >= ADDR_LIM);
    assign aw_idx = s_axi.AWADDR[C_MEM_AW+1:2];
    assign ar_idx = s_axi.ARADDR[C_MEM_AW+1:2];

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (aw_hs)      state_n = S_WDATA;
                else if (ar_hs) state_n = S_RDATA;
            end
            S_WDATA: if (w_hs && w_last)  state_n = S_WRESP;
            S_WRESP: if (b_hs)            state_n = S_IDLE;
            S_RDATA: if (r_hs && rlast_q) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state    <= S_IDLE;
            rdy_q    <= 1'b0;
            wr_pri   <= 1'b1;
            err      <= 1'b0;
            wl_err   <= 1'b0;
            idx      <= '0;
            cnt      <= '0;
            len      <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= 2'b00;
            rvalid_q <= 1'b0;
            rresp_q  <= 2'b00;
            rlast_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state <= state_n;
            rdy_q <= (state_n == S_IDLE);
            if (both && (aw_hs || ar_hs)) wr_pri <= ~wr_pri;
            if (aw_hs) begin
                idx    <= aw_idx;
                len    <= s_axi.AWLEN;
                cnt    <= '0;
                err    <= aw_err;
                wl_err <= 1'b0;
            end
            if (w_hs) begin
                idx    <= idx + C_MEM_AW'(1);
                cnt    <= cnt + 8'd1;
                wl_err <= wl_err | wl_bad;
                if (w_last) begin
                    bvalid_q <= 1'b1;
                    bresp_q  <= (err || wl_err || wl_bad) ? 2'b10 : 2'b00;
                end
            end
            if (b_hs) begin
                bvalid_q <= 1'b0;
                bresp_q  <= 2'b00;
            end
            // Beat 0 is fetched at the AR handshake; idx then runs one word ahead.
            if (ar_hs) begin
                idx      <= ar_idx + C_MEM_AW'(1);
                len      <= s_axi.ARLEN;
                cnt      <= '0;
                err      <= ar_err;
                rvalid_q <= 1'b1;
                rdata_q  <= ar_err ? '0 : mem[ar_idx];
                rresp_q  <= ar_err ? 2'b10 : 2'b00;
                rlast_q  <= (s_axi.ARLEN == 8'd0);
            end
            if (r_hs) begin
                if (rlast_q) begin
                    rvalid_q <= 1'b0;
                    rlast_q  <= 1'b0;
                    rresp_q  <= 2'b00;
                    rdata_q  <= '0;
                end else begin
                    idx     <= idx + C_MEM_AW'(1);
                    cnt     <= cnt + 8'd1;
                    rdata_q <= err ? '0 : mem[idx];
                    rlast_q <= ((cnt + 8'd1) == len);
                end
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESET && w_hs && !err) begin
            for (int b = 0; b < NB; b++) begin
                if (s_axi.WSTRB[b]) mem[idx][8*b +: 8] <= s_axi.WDATA[8*b +: 8];
            end
        end
    end
endmodule
